// File: rtl/alu_mc_pkg.sv
// Shared opcode constants, FSM state type and opcode classification for alu_mc.
// Build macro ALU_MC_DIV_EN decides whether DIVU is a legal opcode.
package alu_mc_pkg;

    localparam logic [5:0] OP_AND   = 6'h00;
    localparam logic [5:0] OP_OR    = 6'h01;
    localparam logic [5:0] OP_ADD   = 6'h02;
    localparam logic [5:0] OP_ADDU  = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_SUB   = 6'h06;
    localparam logic [5:0] OP_SLT   = 6'h07;
    localparam logic [5:0] OP_SLTU  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h09;
    localparam logic [5:0] OP_MULTU = 6'h13;
    localparam logic [5:0] OP_SLLV  = 6'h14;
    localparam logic [5:0] OP_SRLV  = 6'h15;
    localparam logic [5:0] OP_SRAV  = 6'h16;
    localparam logic [5:0] OP_DIVU  = 6'h30;
    localparam logic [5:0] OP_CLIP  = 6'h31;

    localparam int LUI_SHIFT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CLS_SINGLE  = 2'd0,
        CLS_MULT    = 2'd1,
        CLS_DIV     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_t;

    function automatic op_class_t classify(input logic [5:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_ADDU, OP_XOR, OP_SUB, OP_SLT, OP_SLTU,
            OP_LUI, OP_SLLV, OP_SRLV, OP_SRAV, OP_CLIP:
                classify = CLS_SINGLE;
            OP_MULTU:
                classify = CLS_MULT;
`ifdef ALU_MC_DIV_EN
            OP_DIVU:
                classify = CLS_DIV;
`endif
            default:
                classify = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: one shared adder serves shift-add multiply and (with
// ALU_MC_DIV_EN) restoring divide, one bit per step, plus the step counter.
module alu_mc_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
`ifdef ALU_MC_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);

    localparam int CW = $clog2(WIDTH) + 1;

    // hi: partial product high half / partial remainder
    // lo: multiplier being consumed / dividend shifting into quotient
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;
    logic             sub;
    logic [WIDTH:0]   add_a;
    logic [WIDTH+1:0] add_b;
    logic [WIDTH+1:0] sum;

`ifdef ALU_MC_DIV_EN
    logic div_q;
    assign sub = div_q;
`else
    logic unused_carry;
    assign sub          = 1'b0;
    assign unused_carry = sum[WIDTH+1];
`endif

    always_comb begin
        add_a = {1'b0, hi};
        add_b = lo[0] ? {2'b00, m} : '0;
`ifdef ALU_MC_DIV_EN
        if (sub) begin
            add_a = {hi, lo[WIDTH-1]};
            add_b = ~{2'b00, m};
        end
`endif
        sum     = {1'b0, add_a} + add_b + {{(WIDTH+1){1'b0}}, sub};
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        // Top bit set means the trial subtraction borrowed: restore.
        if (sub) begin
            if (!sum[WIDTH+1]) begin
                hi_next = sum[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = add_a[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    assign last = step && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            count <= '0;
`ifdef ALU_MC_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (load) begin
            hi    <= '0;
            count <= '0;
`ifdef ALU_MC_DIV_EN
            div_q <= div_mode;
            lo    <= div_mode ? s : t;
            m     <= div_mode ? t : s;
`else
            lo    <= t;
            m     <= s;
`endif
        end else if (step) begin
            hi    <= hi_next;
            lo    <= lo_next;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/clip ops plus iterative MULTU
// and DIVU. DIVU exists only when ALU_MC_DIV_EN is defined; otherwise 0x30 is illegal.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CLIP_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r2,
    output logic             z,
    output logic             err,
    output state_t           state
);

    localparam int               SW     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] CLIP_W = WIDTH'(CLIP_MAX);

    op_class_t        cls;
    logic [WIDTH-1:0] single_res;
    logic [SW-1:0]    shamt;
    logic             iter_op;
    logic             iter_load;
    logic             iter_step;
    logic             iter_last;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] hi_next;
    logic             div_zero;

    assign shamt     = b[SW-1:0];
    assign iter_op   = (cls == CLS_MULT) || (cls == CLS_DIV);
    assign iter_load = (state == IDLE) && start && iter_op;
    assign iter_step = (state == RUN);

    always_comb begin
        cls        = classify(ctrl);
        single_res = '0;
        case (ctrl)
            OP_AND:  single_res = a & b;
            OP_OR:   single_res = a | b;
            OP_ADD:  single_res = a + b;
            OP_ADDU: single_res = a + b;
            OP_XOR:  single_res = a ^ b;
            OP_SUB:  single_res = a - b;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_LUI:  single_res = b << LUI_SHIFT;
            OP_SLLV: single_res = a << shamt;
            OP_SRLV: single_res = a >> shamt;
            OP_SRAV: single_res = $signed(a) >>> shamt;
            OP_CLIP: begin
                // Negative inputs are caught by the sign bit, so the upper
                // bound compare can stay unsigned.
                if (a[WIDTH-1])
                    single_res = '0;
                else if (a > CLIP_W)
                    single_res = CLIP_W;
                else
                    single_res = a;
            end
            default: single_res = '0;
        endcase
    end

    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (iter_load),
        .step     (iter_step),
`ifdef ALU_MC_DIV_EN
        .div_mode (cls == CLS_DIV),
`endif
        .s        (a),
        .t        (b),
        .last     (iter_last),
        .lo_next  (lo_next),
        .hi_next  (hi_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            r        <= '0;
            r2       <= '0;
            z        <= 1'b0;
            err      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (iter_op) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            div_zero <= (cls == CLS_DIV) && (b == '0);
                        end else begin
                            r    <= single_res;
                            r2   <= '0;
                            z    <= (single_res == '0);
                            err  <= (cls == CLS_ILLEGAL);
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The last step's result goes straight into the output registers.
                    if (iter_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        r     <= lo_next;
                        r2    <= hi_next;
                        z     <= (lo_next == '0);
                        err   <= div_zero;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 Parameter CLIP_MAX, default 255, upper bound for the CLIP operation.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 start  in  1  operation request; sampled only when busy=0.
REQ-006 ctrl  in  6  opcode, captured with start.
REQ-007 a  in  WIDTH  operand s, captured with start.
REQ-008 b  in  WIDTH  operand t, captured with start.
REQ-009 busy  out  1  iterative operation in progress.
REQ-010 done  out  1  one-cycle pulse; r/r2/z/err are valid.
REQ-011 r  out  WIDTH  result low / quotient.
REQ-012 r2  out  WIDTH  result high / remainder; 0 for single-cycle ops.
REQ-013 z  out  1  r equals 0.
REQ-014 err  out  1  illegal opcode or divide-by-zero.

Function
REQ-015 Opcodes SHALL be: 0x00 AND, 0x01 OR, 0x02 ADD, 0x03 ADDU, 0x04 XOR, 0x06 SUB, 0x07 SLT (signed), 0x08 SLTU, 0x09 LUI (t<<16, bits above WIDTH dropped), 0x14 SLLV, 0x15 SRLV, 0x16 SRAV, 0x13 MULTU, 0x30 DIVU, 0x31 CLIP.
REQ-016 Variable shifts SHALL use shift amount t[log2(WIDTH)-1:0] applied to s; SRAV replicates s[WIDTH-1].
REQ-017 CLIP SHALL treat s as signed: s<0 gives 0; s>CLIP_MAX gives CLIP_MAX; otherwise s.
REQ-018 ADD/ADDU/SUB SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-019 FSM states SHALL be IDLE, RUN. IDLE to RUN on accepted start of MULTU/DIVU; RUN to IDLE after iteration count reaches WIDTH.
REQ-020 Single-cycle ops SHALL update outputs and pulse done at the first rising edge after the accepted start; busy stays 0.
REQ-021 MULTU SHALL be iterative shift-add, one bit per cycle, producing r=product[WIDTH-1:0], r2=product[2*WIDTH-1:WIDTH].
REQ-022 DIVU SHALL be iterative restoring division, one bit per cycle, producing r=quotient, r2=remainder.
REQ-023 Iterative ops SHALL pulse done exactly WIDTH+1 edges after the accepted start; busy=1 from edge 1 through edge WIDTH, and 0 in the done cycle.
REQ-024 start while busy=1 SHALL be ignored; operands captured at acceptance are unaffected by later input changes.
REQ-025 start in the done cycle SHALL be accepted (back-to-back operation).
REQ-026 r, r2, z, err SHALL hold their values until the next done pulse.
REQ-027 Divide by zero SHALL give r=all ones, r2=s, err=1, with the normal WIDTH+1 latency.
REQ-028 An illegal opcode SHALL give r=0, r2=0, z=1, err=1, with done after 1 cycle.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, iteration counter=0, and busy, done, r, r2, z, err all to 0, including in the middle of an operation.
REQ-030 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro ALU_MC_DIV_EN, defined: DIVU is implemented per REQ-022/REQ-027.
REQ-032 ALU_MC_DIV_EN undefined: no divider logic is present; 0x30 is handled as an illegal opcode per REQ-028.

Structure
REQ-033 Package alu_mc_pkg SHALL hold the opcode constants and the FSM state typedef.
REQ-034 Sub-module alu_mc_iter SHALL hold the shared shift/add-subtract iterative datapath and the counter; alu_mc holds the decode, single-cycle ops and output registers.

Verification (WIDTH=32)
REQ-035 ADD a=0x7FFFFFFF, b=1 -> r=0x80000000, z=0, err=0, done 1 cycle after start.
REQ-036 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> r=0x00000001, r2=0xFFFFFFFE, done at edge 33; a second start at edge 5 is ignored.
REQ-037 DIVU a=300, b=13 -> r=23, r2=1; DIVU b=0 -> r=0xFFFFFFFF, r2=a, err=1; without ALU_MC_DIV_EN -> r=0, err=1 after 1 cycle.
REQ-038 SRAV a=0x80000000, b=4 -> r=0xF8000000; CLIP a=-5 -> 0, a=300 -> 255, a=100 -> 100.
REQ-039 rst_n pulsed low at edge 10 of a MULTU -> busy=0, done=0, r=0 immediately; the next op behaves normally.
REQ-040 Illegal ctrl=0x3F -> r=0, z=1, err=1; a start in the done cycle of a MULTU is accepted.
